exe_muldiv: RTL and testbench
=============================

# exe_muldiv

Iterative multiply/divide unit alongside the EXE stage of the 5-stage pipelined CPU. It consumes the forwarded EXE operands (ra/rb values) of MULT, MULTU, DIV, DIVU, MTHI and MTLO, computes products and quotients in a radix-2 loop, and holds the architectural HI/LO registers. It also produces a stall request that is ORed into the existing hazard stall, so that an ID-stage instruction that needs HI/LO waits while the unit is busy.

## Interface
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

- Clock  in  1  rising-edge clock.
- Resetn  in  1  reset; synchronous, active-high (asserted when 1).
- start  in  1  EXE holds a valid muldiv-class op this cycle.
- op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
- a  in  WIDTH  rs operand (exe_ra).
- b  in  WIDTH  rt operand (exe_rb).
- id_hilo_use  in  1  the ID-stage instruction is MFHI, MFLO or a muldiv-class op.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  registered; 1 while a MULT/DIV is in progress.
- stall  out  1  combinational: busy & id_hilo_use.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - Latch the operand magnitudes (absolute values for signed ops; raw values for unsigned ops).
  - Latch the result sign flags and op.
  - Clear the 6-bit iteration counter.
  - Move to CALC. busy=1 from the next cycle.
- IDLE, start=1, op MTHI/MTLO: hi<=a or lo<=a at that edge. State stays IDLE.
- IDLE with start=0, or op none: no change.
- CALC, one iteration per cycle:
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract giving quotient and remainder.
  - After WIDTH iterations (counter = WIDTH-1 at the edge), move to FIX.
- FIX, one cycle:
  - Apply sign correction. Product is negated when the operand signs differ. Quotient is negated when the signs differ. Remainder takes the sign of the dividend.
  - Write hi/lo: product {hi,lo}; quotient to lo, remainder to hi.
  - Return to IDLE and clear busy.
- Any start while in CALC or FIX (including MTHI/MTLO) is ignored. Upstream guarantees this never happens via stall; the RTL must still ignore it.
- Divide by zero (b=0), signed or unsigned: lo=0xFFFFFFFF, hi=a (raw), no sign fix. Latency is unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- Signed division truncates toward zero.
- Width rules: all arithmetic is modulo 2^WIDTH per register. The multiply accumulator is 2*WIDTH bits. Negation is two's complement.

## Timing
- Reset: state=IDLE, hi=0, lo=0, busy=0, counter=0. stall=0 because busy=0.
- Reset while in CALC/FIX aborts the operation. hi/lo are cleared, not written with partial results.
- Start accepted at edge E0:
  - busy=1 in the cycles following E0 through E(WIDTH+1).
  - hi/lo take the new result at edge E(WIDTH+1), which is E33 for WIDTH=32.
  - busy=0 in the cycle following E33.
- Back-to-back operations: a new start is accepted at E33+1 at the earliest. Total throughput is 34 cycles per op.
- MTHI/MTLO: one-cycle write; hi/lo are visible in the cycle after the edge.
- hi/lo are stable (unchanged) throughout CALC/FIX; they hold the previous result.
- stall follows id_hilo_use combinationally in the same cycle while busy=1. It deasserts in the first cycle after E33.
- Reset has priority over start in the same cycle.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles; hi=0xFFFFFFFE, lo=0x00000001 after E33; busy=0 next cycle.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7 -> lo=14, hi=2. DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- During a DIVU: hold id_hilo_use=1 -> stall=1 every busy cycle, 0 after E33. Pulse start with MTLO a=0xDEAD during busy -> ignored, lo ends equal to the quotient.
- MTHI a=0xCAFEBABE, then MTLO a=0x1 on consecutive cycles in IDLE -> hi=0xCAFEBABE, lo=1, busy never set.
- Start MULT 7*9, assert Resetn at cycle 10 of CALC -> hi=lo=0, busy=0 next cycle. A following MULTU 7*9 -> lo=63, hi=0 after 33 cycles.

Source files
------------

// File: rtl/exe_muldiv.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// One iteration per cycle in CALC, sign correction and HI/LO write-back in FIX.
module exe_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             id_hilo_use,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_NONE7 = 3'd7
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d, op_in;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;

  logic               signed_op, is_mul;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, shifted_hi, diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    araw_d    = araw_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;

    op_in     = op_e'(op);
    signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;
    is_mul    = (op_q == OP_MULT) || (op_q == OP_MULTU);

    // Multiply: low half of acc holds the multiplier, partial product shifts in from the top.
    sum        = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    // Divide: high half is the partial remainder, low half the dividend/quotient shift register.
    shifted_hi = acc_q[2*WIDTH-1:WIDTH-1];
    diff       = shifted_hi - {1'b0, mcand_q};
    prod       = neg_res_q ? -acc_q : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op_in)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_d      = op_in;
              mcand_d   = mag_b;
              acc_d     = {{WIDTH{1'b0}}, mag_a};
              araw_d    = a;
              div0_d    = (b == '0);
              neg_res_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_d = signed_op && a[WIDTH-1];
              cnt_d     = '0;
              busy_d    = 1'b1;
              state_d   = S_CALC;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (is_mul) begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
          acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {shifted_hi[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_mul) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else begin
          lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NONE;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      araw_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      araw_q    <= araw_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign stall = busy_q & id_hilo_use;

endmodule

// File: tb/tb_exe_muldiv.sv
// Bench for exe_muldiv: directed and random MULT/DIV/MTHI/MTLO traffic checked
// against an arithmetic reference model, including latency, stall and reset behaviour.
module tb_exe_muldiv;

  localparam int unsigned W = 32;

  logic         Clock = 1'b0;
  logic         Resetn;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         id_hilo_use;
  logic [W-1:0] hi, lo;
  logic         busy, stall;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  exe_muldiv #(.WIDTH(W)) dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .op(op), .a(a), .b(b),
    .id_hilo_use(id_hilo_use), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint          ps;
    longint unsigned pu;
    int              sq, sr;
    case (o)
      3'd1: begin ps = longint'($signed(x)) * longint'($signed(y)); return ps; end
      3'd2: begin pu = 64'(x) * 64'(y); return pu; end
      3'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {32'(sr), 32'(sq)};
      end
      3'd4: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return {exp_hi, exp_lo};
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic idu, input logic inject);
    logic [63:0] r;
    @(negedge Clock);
    start = 1'b1; op = o; a = x; b = y; id_hilo_use = idu;
    @(negedge Clock);
    start = 1'b0; op = 3'd0;
    for (int i = 0; i < 33; i++) begin
      chk("busy_during", 64'(busy), 64'(1'b1));
      chk("stall_during", 64'(stall), 64'(idu));
      chk("hi_hold", 64'(hi), 64'(exp_hi));
      chk("lo_hold", 64'(lo), 64'(exp_lo));
      if (inject && i == 5) begin start = 1'b1; op = 3'd6; a = 32'hDEAD; end
      else begin start = 1'b0; op = 3'd0; end
      @(negedge Clock);
    end
    start = 1'b0;
    r = ref_op(o, x, y);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    chk("busy_done", 64'(busy), 64'(1'b0));
    chk("stall_done", 64'(stall), 64'(1'b0));
    chk("hi_result", 64'(hi), 64'(exp_hi));
    chk("lo_result", 64'(lo), 64'(exp_lo));
    id_hilo_use = 1'b0;
  endtask

  initial begin
    Resetn = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; id_hilo_use = 1'b1;
    repeat (2) @(negedge Clock);
    Resetn = 1'b0;
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    id_hilo_use = 1'b0;

    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max_lo", 64'(lo), 64'h0000_0001);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    chk("mult_neg_lo", 64'(lo), 64'hFFFF_FFF1);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(3'd4, 32'd100, 32'd7, 1'b0, 1'b0);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);
    run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    chk("divu0_hi", 64'(hi), 64'h1234_5678);
    run_op(3'd3, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
    chk("div0_hi_raw", 64'(hi), 64'hFFFF_FF00);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
    run_op(3'd4, 32'd1000, 32'd3, 1'b1, 1'b1);
    chk("inject_lo", 64'(lo), 64'd333);

    // MTHI then MTLO on consecutive idle cycles
    @(negedge Clock);
    start = 1'b1; op = 3'd5; a = 32'hCAFE_BABE;
    @(negedge Clock);
    chk("mthi_hi", 64'(hi), 64'hCAFE_BABE);
    chk("mthi_busy", 64'(busy), 64'h0);
    op = 3'd6; a = 32'h1;
    @(negedge Clock);
    start = 1'b0; op = 3'd0;
    exp_hi = 32'hCAFE_BABE; exp_lo = 32'h1;
    chk("mtlo_lo", 64'(lo), 64'h1);
    chk("mtlo_hi", 64'(hi), 64'hCAFE_BABE);
    chk("mtlo_busy", 64'(busy), 64'h0);

    // Reset takes priority over a same-cycle start
    Resetn = 1'b1; start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd9;
    @(negedge Clock);
    Resetn = 1'b0; start = 1'b0; op = 3'd0;
    exp_hi = '0; exp_lo = '0;
    chk("rstprio_busy", 64'(busy), 64'h0);
    chk("rstprio_hi", 64'(hi), 64'h0);
    @(negedge Clock);
    chk("rstprio_busy2", 64'(busy), 64'h0);

    run_op(3'd2, 32'd11, 32'd13, 1'b0, 1'b0);
    // Abort a MULT ten cycles into CALC
    @(negedge Clock);
    start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd9;
    @(negedge Clock);
    start = 1'b0; op = 3'd0;
    repeat (10) @(negedge Clock);
    chk("abort_busy_pre", 64'(busy), 64'h1);
    Resetn = 1'b1;
    @(negedge Clock);
    Resetn = 1'b0;
    exp_hi = '0; exp_lo = '0;
    chk("abort_hi", 64'(hi), 64'h0);
    chk("abort_lo", 64'(lo), 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    run_op(3'd2, 32'd7, 32'd9, 1'b0, 1'b0);
    chk("after_abort_lo", 64'(lo), 64'd63);

    for (int k = 0; k < 10; k++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
